// File: rtl/serdesphy_pkg.sv
// Shared PCS definitions: PRBS-7 polynomial, nibble width, checker FSM encoding and the
// four-bit-unrolled LFSR step used by both the TX generator and the RX checker.
package serdesphy_pkg;

    localparam int PRBS7_TAP_A = 6;
    localparam int PRBS7_TAP_B = 5;
    localparam int NIB_W       = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEED   = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] LOCKED = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SEED   = SEED,
        ST_CHECK  = CHECK,
        ST_LOCKED = LOCKED
    } state_t;

    // Returns {next_s, pred}; pred[3] is the oldest (first transmitted) bit.
    function automatic logic [10:0] prbs7_step4(input logic [6:0] s);
        logic [6:0]       st;
        logic [NIB_W-1:0] pred;
        logic             b;
        st   = s;
        pred = '0;
        for (int i = NIB_W - 1; i >= 0; i--) begin
            b       = st[PRBS7_TAP_A] ^ st[PRBS7_TAP_B];
            pred[i] = b;
            st      = {st[5:0], b};
        end
        return {st, pred};
    endfunction

endpackage

// File: rtl/serdesphy_prbs7_checker_if.sv
// RX nibble stream, control and status bundle between the PCS datapath and the PRBS-7 checker.
interface serdesphy_prbs7_checker_if #(
    parameter int ERR_W = 16
);
    logic             enable;
    logic             clear;
    logic [3:0]       rx_data;
    logic             rx_valid;
    logic             prbs_lock;
    logic             prbs_err;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output enable, clear, rx_data, rx_valid,
        input  prbs_lock, prbs_err, err_pulse, err_count
    );

    modport slave (
        input  enable, clear, rx_data, rx_valid,
        output prbs_lock, prbs_err, err_pulse, err_count
    );
endinterface

// File: rtl/serdesphy_popcount4.sv
// Combinational population count of one nibble (0..4).
module serdesphy_popcount4 (
    input  logic [3:0] i_nibble,
    output logic [2:0] o_count
);
    logic [1:0] w_pair [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pair
            assign w_pair[gi] = {1'b0, i_nibble[2*gi]} + {1'b0, i_nibble[2*gi+1]};
        end
    endgenerate

    assign o_count = {1'b0, w_pair[0]} + {1'b0, w_pair[1]};
endmodule

// File: rtl/serdesphy_prbs7_checker.sv
// Self-synchronising PRBS-7 checker on the recovered RX nibble stream: seeds from received
// bits, verifies a run of predictions before locking, then counts bit errors while locked.
module serdesphy_prbs7_checker
    import serdesphy_pkg::*;
#(
    parameter int LOCK_NIBBLES = 8,
    parameter int LOSS_NIBBLES = 4,
    parameter int ERR_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    serdesphy_prbs7_checker_if.slave  bus
);
    localparam int GOOD_W = $clog2(LOCK_NIBBLES + 1);
    localparam int ZERO_W = $clog2(2 * LOCK_NIBBLES + 1);
    localparam int BAD_W  = $clog2(LOSS_NIBBLES + 1);

    state_t            r_state,      w_state_next;
    logic [6:0]        r_s,          w_s_next;
    logic              r_seed_cnt,   w_seed_cnt_next;
    logic [GOOD_W-1:0] r_good_run,   w_good_run_next;
    logic [ZERO_W-1:0] r_zero_run,   w_zero_run_next;
    logic [BAD_W-1:0]  r_bad_run,    w_bad_run_next;
    logic [ERR_W-1:0]  r_err_count,  w_err_count_next;
    logic              r_prbs_err,   w_prbs_err_next;
    logic              r_err_pulse,  w_err_pulse_next;
    logic              r_prbs_lock,  w_prbs_lock_next;

    logic [6:0]       w_step_s;
    logic [NIB_W-1:0] w_pred;
    logic [NIB_W-1:0] w_xor;
    logic [2:0]       w_nerr;
    logic [ERR_W:0]   w_sum;
    logic [ERR_W-1:0] w_sat;

    assign {w_step_s, w_pred} = prbs7_step4(r_s);
    assign w_xor = w_pred ^ bus.rx_data;

    serdesphy_popcount4 u_popcount (
        .i_nibble (w_xor),
        .o_count  (w_nerr)
    );

    assign w_sum = {1'b0, r_err_count} + {{(ERR_W-2){1'b0}}, w_nerr};
    assign w_sat = w_sum[ERR_W] ? {ERR_W{1'b1}} : w_sum[ERR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_seed_cnt  <= 1'b0;
            r_good_run  <= '0;
            r_zero_run  <= '0;
            r_bad_run   <= '0;
            r_err_count <= '0;
            r_prbs_err  <= 1'b0;
            r_err_pulse <= 1'b0;
            r_prbs_lock <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_s         <= w_s_next;
            r_seed_cnt  <= w_seed_cnt_next;
            r_good_run  <= w_good_run_next;
            r_zero_run  <= w_zero_run_next;
            r_bad_run   <= w_bad_run_next;
            r_err_count <= w_err_count_next;
            r_prbs_err  <= w_prbs_err_next;
            r_err_pulse <= w_err_pulse_next;
            r_prbs_lock <= w_prbs_lock_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_s_next         = r_s;
        w_seed_cnt_next  = r_seed_cnt;
        w_good_run_next  = r_good_run;
        w_zero_run_next  = r_zero_run;
        w_bad_run_next   = r_bad_run;
        w_err_count_next = r_err_count;
        w_prbs_err_next  = r_prbs_err;
        w_err_pulse_next = 1'b0;
        w_prbs_lock_next = r_prbs_lock;

        if (!bus.enable) begin
            w_state_next     = ST_IDLE;
            w_prbs_lock_next = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next    = ST_SEED;
                    w_seed_cnt_next = 1'b0;
                end
                ST_SEED: if (bus.rx_valid) begin
                    w_s_next        = {r_s[2:0], bus.rx_data};
                    w_seed_cnt_next = 1'b1;
                    if (r_seed_cnt) begin
                        w_state_next    = ST_CHECK;
                        w_seed_cnt_next = 1'b0;
                        w_good_run_next = '0;
                        w_zero_run_next = '0;
                    end
                end
                ST_CHECK: if (bus.rx_valid) begin
                    w_s_next = w_step_s;
                    if (w_pred != bus.rx_data) begin
                        w_state_next    = ST_SEED;
                        w_seed_cnt_next = 1'b0;
                    end else begin
                        w_zero_run_next = (bus.rx_data == '0) ? r_zero_run + 1'b1 : '0;
                        // A zero seed predicts zeros forever, so it never earns lock credit.
                        if (r_s != '0) begin
                            w_good_run_next = r_good_run + 1'b1;
                        end
                        if ((bus.rx_data == '0) && (r_zero_run == ZERO_W'(2 * LOCK_NIBBLES - 1))) begin
                            w_state_next    = ST_SEED;
                            w_seed_cnt_next = 1'b0;
                        end else if ((r_s != '0) && (r_good_run == GOOD_W'(LOCK_NIBBLES - 1))) begin
                            w_state_next     = ST_LOCKED;
                            w_prbs_lock_next = 1'b1;
                            w_bad_run_next   = '0;
                        end
                    end
                end
                ST_LOCKED: if (bus.rx_valid) begin
                    w_s_next = w_step_s;
                    if (w_nerr != 3'd0) begin
                        w_err_count_next = w_sat;
                        w_prbs_err_next  = 1'b1;
                        w_err_pulse_next = 1'b1;
                        w_bad_run_next   = r_bad_run + 1'b1;
                        if (r_bad_run == BAD_W'(LOSS_NIBBLES - 1)) begin
                            w_state_next     = ST_SEED;
                            w_seed_cnt_next  = 1'b0;
                            w_prbs_lock_next = 1'b0;
                        end
                    end else begin
                        w_bad_run_next = '0;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end

        // Clear beats a coincident error; the pulse still reports that nibble.
        if (bus.clear) begin
            w_err_count_next = '0;
            w_prbs_err_next  = 1'b0;
        end
    end

    assign bus.prbs_lock = r_prbs_lock;
    assign bus.prbs_err  = r_prbs_err;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
endmodule

// File: tb/tb_serdesphy_prbs7_checker.sv
// Bench for the PRBS-7 checker: a 16-bit and a 4-bit counter instance share one stimulus
// stream; a table of segments holds hand-derived end states, a scoreboard checks every cycle.
module tb_serdesphy_prbs7_checker;

    typedef struct {
        string      name;
        int         nib;
        logic [3:0] xmask;
        int         err_idx;
        int         gap_max;
        bit         en;
        bit         clr;
        bit         jump;
        bit         zero;
        int         exp_lock;
        int         exp_cnt;
        int         exp_cnt4;
        int         exp_err;
    } seg_t;

    typedef struct {
        bit lock;
        bit err;
        bit pulse;
        int cnt16;
        int cnt4;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_r = 1'b0;
    logic       clr_r = 1'b0;
    logic       vld_r = 1'b0;
    logic [3:0] data_r = 4'h0;

    int checks = 0;
    int failures = 0;

    seg_t segq[$];
    exp_t sbq[$];

    logic [6:0] g = 7'h7F;

    int         m_state, m_seed, m_good, m_zero, m_bad, m_cnt16, m_cnt4;
    logic [6:0] m_s;
    bit         m_err, m_pulse, m_lock;

    always #5 clk = ~clk;

    serdesphy_prbs7_checker_if #(.ERR_W(16)) bus16 ();
    serdesphy_prbs7_checker_if #(.ERR_W(4))  bus4 ();

    assign bus16.enable   = en_r;
    assign bus16.clear    = clr_r;
    assign bus16.rx_valid = vld_r;
    assign bus16.rx_data  = data_r;
    assign bus4.enable    = en_r;
    assign bus4.clear     = clr_r;
    assign bus4.rx_valid  = vld_r;
    assign bus4.rx_data   = data_r;

    serdesphy_prbs7_checker #(.LOCK_NIBBLES(8), .LOSS_NIBBLES(4), .ERR_W(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    serdesphy_prbs7_checker #(.LOCK_NIBBLES(8), .LOSS_NIBBLES(4), .ERR_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic add(input string nm, input int nib, input logic [3:0] xm, input int idx,
                       input int gap, input bit en, input bit clr, input bit jump, input bit zero,
                       input int el, input int ec, input int ec4, input int ee);
        seg_t s;
        s.name = nm;  s.nib = nib;  s.xmask = xm;  s.err_idx = idx;  s.gap_max = gap;
        s.en = en;  s.clr = clr;  s.jump = jump;  s.zero = zero;
        s.exp_lock = el;  s.exp_cnt = ec;  s.exp_cnt4 = ec4;  s.exp_err = ee;
        segq.push_back(s);
    endtask

    task automatic gen_nibble(output logic [3:0] n);
        logic b;
        for (int k = 3; k >= 0; k--) begin
            b    = g[6] ^ g[5];
            n[k] = b;
            g    = {g[5:0], b};
        end
    endtask

    task automatic gen_advance(input int bits);
        for (int k = 0; k < bits; k++) g = {g[5:0], g[6] ^ g[5]};
    endtask

    task automatic model_reset();
        m_state = 0; m_seed = 0; m_good = 0; m_zero = 0; m_bad = 0;
        m_cnt16 = 0; m_cnt4 = 0; m_s = '0; m_err = 0; m_pulse = 0; m_lock = 0;
    endtask

    // Bit-serial reference of the checker behaviour, one call per clock.
    task automatic model_step(input bit en, input bit clr, input bit vld, input logic [3:0] d);
        logic [3:0] pred;
        logic [6:0] ns;
        int         nerr;
        bit         zero_seed;
        ns = m_s;
        for (int k = 3; k >= 0; k--) begin
            pred[k] = ns[6] ^ ns[5];
            ns      = {ns[5:0], pred[k]};
        end
        nerr      = $countones(pred ^ d);
        zero_seed = (m_s == 7'd0);
        m_pulse   = 0;
        if (!en) begin
            m_state = 0;
            m_lock  = 0;
        end else begin
            case (m_state)
                0: begin m_state = 1; m_seed = 0; end
                1: if (vld) begin
                    for (int k = 3; k >= 0; k--) m_s = {m_s[5:0], d[k]};
                    m_seed++;
                    if (m_seed == 2) begin m_state = 2; m_seed = 0; m_good = 0; m_zero = 0; end
                end
                2: if (vld) begin
                    m_s = ns;
                    if (pred != d) begin
                        m_state = 1; m_seed = 0;
                    end else begin
                        m_zero = (d == 4'h0) ? m_zero + 1 : 0;
                        if (!zero_seed) m_good++;
                        if (m_zero == 16) begin m_state = 1; m_seed = 0; end
                        else if (m_good == 8) begin m_state = 3; m_lock = 1; m_bad = 0; end
                    end
                end
                default: if (vld) begin
                    m_s = ns;
                    if (nerr != 0) begin
                        m_cnt16 = (m_cnt16 + nerr > 65535) ? 65535 : m_cnt16 + nerr;
                        m_cnt4  = (m_cnt4 + nerr > 15) ? 15 : m_cnt4 + nerr;
                        m_err   = 1;
                        m_pulse = 1;
                        m_bad++;
                        if (m_bad == 4) begin m_state = 1; m_seed = 0; m_lock = 0; end
                    end else begin
                        m_bad = 0;
                    end
                end
            endcase
        end
        if (clr) begin m_cnt16 = 0; m_cnt4 = 0; m_err = 0; end
    endtask

    task automatic drive_cycle(input string nm, input bit en, input bit clr, input bit vld,
                               input logic [3:0] d);
        exp_t e;
        en_r = en; clr_r = clr; vld_r = vld; data_r = d;
        model_step(en, clr, vld, d);
        e.lock = m_lock; e.err = m_err; e.pulse = m_pulse; e.cnt16 = m_cnt16; e.cnt4 = m_cnt4;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({nm, ".sb_lock"},  int'(bus16.prbs_lock), int'(e.lock));
        check({nm, ".sb_pulse"}, int'(bus16.err_pulse), int'(e.pulse));
        check({nm, ".sb_err"},   int'(bus16.prbs_err),  int'(e.err));
        check({nm, ".sb_cnt16"}, int'(bus16.err_count), e.cnt16);
        check({nm, ".sb_cnt4"},  int'(bus4.err_count),  e.cnt4);
        check({nm, ".sb_lock4"}, int'(bus4.prbs_lock),  int'(e.lock));
    endtask

    initial begin
        seg_t       s;
        bit         cur_en;
        bit         hit;
        int         gaps;
        logic [3:0] nib;

        //   name          nib mask  idx gap en clr jmp zero lock cnt cnt4 err
        add("lock9",        9, 4'h0, -1, 0, 1, 0, 0, 0,   0,   0,  0, 0);
        add("lock10",       1, 4'h0, -1, 0, 1, 0, 0, 0,   1,   0,  0, 0);
        add("err_bit2",     3, 4'h4,  0, 0, 1, 0, 0, 0,   1,   1,  1, 1);
        add("err_3bit",     2, 4'hB,  0, 0, 1, 0, 0, 0,   1,   4,  4, 1);
        add("loss3",        3, 4'hF, -1, 0, 1, 0, 0, 0,   1,  16, 15, 1);
        add("loss4",        1, 4'hF, -1, 0, 1, 0, 0, 0,   0,  20, 15, 1);
        add("relock9",      9, 4'h0, -1, 0, 1, 0, 0, 0,   0,  20, 15, 1);
        add("relock10",     1, 4'h0, -1, 0, 1, 0, 0, 0,   1,  20, 15, 1);
        add("clr_err",      1, 4'h1,  0, 0, 1, 1, 0, 0,   1,   0,  0, 0);
        add("err_after",    2, 4'h1,  0, 0, 1, 0, 0, 0,   1,   1,  1, 1);
        add("gaps_run",    20, 4'h0, -1, 5, 1, 0, 0, 0,   1,   1,  1, 1);
        add("disable",      1, 4'h0, -1, 0, 0, 0, 0, 0,   0,   1,  1, 1);
        add("gap9",         9, 4'h0, -1, 5, 1, 0, 1, 0,   0,   1,  1, 1);
        add("gap10",        1, 4'h0, -1, 5, 1, 0, 0, 0,   1,   1,  1, 1);
        add("disable2",     1, 4'h0, -1, 0, 0, 0, 0, 0,   0,   1,  1, 1);
        add("chk_err",      5, 4'h8,  4, 0, 1, 0, 1, 0,   0,   1,  1, 1);
        add("after_chk9",   9, 4'h0, -1, 0, 1, 0, 0, 0,   0,   1,  1, 1);
        add("after_chk10",  1, 4'h0, -1, 0, 1, 0, 0, 0,   1,   1,  1, 1);
        add("disable3",     1, 4'h0, -1, 0, 0, 0, 0, 0,   0,   1,  1, 1);
        add("zeros18",     18, 4'h0, -1, 0, 1, 0, 0, 1,   0,   1,  1, 1);
        add("zero_then9",   9, 4'h0, -1, 0, 1, 0, 1, 0,   0,   1,  1, 1);
        add("zero_then10",  1, 4'h0, -1, 0, 1, 0, 0, 0,   1,   1,  1, 1);
        add("err_final",    1, 4'h2,  0, 0, 1, 0, 0, 0,   1,   2,  2, 1);

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset.lock",  int'(bus16.prbs_lock), 0);
        check("reset.err",   int'(bus16.prbs_err),  0);
        check("reset.pulse", int'(bus16.err_pulse), 0);
        check("reset.cnt16", int'(bus16.err_count), 0);
        check("reset.cnt4",  int'(bus4.err_count),  0);
        rst = 1'b0;

        cur_en = 1'b0;
        foreach (segq[i]) begin
            s = segq[i];
            if (s.en && !cur_en) drive_cycle({s.name, ".en"}, 1'b1, 1'b0, 1'b0, 4'($urandom));
            cur_en = s.en;
            if (s.jump) gen_advance(int'($urandom_range(1, 126)));
            for (int n = 0; n < s.nib; n++) begin
                gaps = (s.gap_max > 0) ? int'($urandom_range(0, s.gap_max)) : 0;
                for (int k = 0; k < gaps; k++) drive_cycle(s.name, s.en, 1'b0, 1'b0, 4'($urandom));
                if (s.zero) nib = 4'h0;
                else        gen_nibble(nib);
                hit = (s.err_idx < 0) || (n == s.err_idx);
                drive_cycle(s.name, s.en, s.clr && hit, 1'b1, hit ? (nib ^ s.xmask) : nib);
            end
            check({s.name, ".lock"},  int'(bus16.prbs_lock), s.exp_lock);
            check({s.name, ".lock4"}, int'(bus4.prbs_lock),  s.exp_lock);
            check({s.name, ".cnt16"}, int'(bus16.err_count), s.exp_cnt);
            check({s.name, ".cnt4"},  int'(bus4.err_count),  s.exp_cnt4);
            check({s.name, ".err"},   int'(bus16.prbs_err),  s.exp_err);
            check({s.name, ".err4"},  int'(bus4.prbs_err),   s.exp_err);
        end

        // Asynchronous reset between clock edges while locked with a pending pulse and count.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.lock",  int'(bus16.prbs_lock), 0);
        check("async_rst.err",   int'(bus16.prbs_err),  0);
        check("async_rst.pulse", int'(bus16.err_pulse), 0);
        check("async_rst.cnt16", int'(bus16.err_count), 0);
        check("async_rst.cnt4",  int'(bus4.err_count),  0);
        check("async_rst.lock4", int'(bus4.prbs_lock),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
